// File: rtl/wide_add_seq.sv
// Sequential W-bit adder/subtractor built from one N-bit adder stepped over K chunks.
// The result is published only once the last chunk has been accumulated.

module wide_add_seq_adder #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_c,
  output logic         cout_c
);

  assign {cout_c, sum_c} = (N+1)'(a_i) + (N+1)'(b_i) + (N+1)'(cin_i);

endmodule

module wide_add_seq #(
  parameter int unsigned N = 16,
  parameter int unsigned K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sub,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] result,
  output logic           cout
);

  localparam int unsigned W  = N * K;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [N-1:0]    a_chunk;
  logic [N-1:0]    b_chunk;
  logic [N-1:0]    add_b;
  logic [N-1:0]    add_sum;
  logic            add_cout;

  // Select the current chunk of the latched operands; subtraction is a + ~b + 1.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned k = 0; k < K; k++) begin
      if (cnt_q == CW'(k)) begin
        a_chunk = a_q[k*N +: N];
        b_chunk = b_q[k*N +: N];
      end
    end
    add_b = b_chunk ^ {N{sub_q}};
  end

  wide_add_seq_adder #(.N(N)) u_adder (
    .a_i    (a_chunk),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_c  (add_sum),
    .cout_c (add_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          cnt_d   = '0;
          carry_d = sub;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < K; k++) begin
          if (cnt_q == CW'(k)) begin
            acc_d[k*N +: N] = add_sum;
          end
        end
        carry_d = add_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          result_d = acc_d;
          cout_d   = add_cout;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 The module SHALL have parameter N, default 16, giving the chunk width in bits of the single shared adder datapath.
REQ-002 The module SHALL have parameter K, default 4, giving the number of chunks (K >= 1); the operand width is W = N*K.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 The module SHALL have port start, input, 1 bit, a request to begin an operation.
REQ-006 The module SHALL have port sub, input, 1 bit: 0 selects a+b, 1 selects a-b; it is sampled with start.
REQ-007 The module SHALL have port a, input, W bits, operand A, sampled with start.
REQ-008 The module SHALL have port b, input, W bits, operand B, sampled with start.
REQ-009 The module SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-010 The module SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 The module SHALL have port result, output, W bits, the sum or difference modulo 2^W.
REQ-012 The module SHALL have port cout, output, 1 bit, the final carry; for sub this is 1 when no borrow occurs (a >= b unsigned).

Function
REQ-013 The module SHALL instantiate exactly one adder with parameter N as its only arithmetic; no other W-bit or N-bit adders are permitted.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL latch a, b and sub, set the chunk counter to 0, load the carry register with sub, and move to RUN.
REQ-016 In RUN, each cycle SHALL apply chunk cnt (bits cnt*N+N-1 : cnt*N, LSB chunk first) to the adder.
REQ-017 During RUN, the adder's b input SHALL be the chunk of the latched b, bitwise inverted when the latched sub=1.
REQ-018 During RUN, the adder's cin SHALL be the carry register.
REQ-019 At each RUN edge, the adder sum SHALL be stored into the chunk cnt position of an internal accumulator, the adder cout SHALL be stored into the carry register, and cnt SHALL increment.
REQ-020 At the RUN edge where cnt = K-1, the completed accumulator SHALL be copied to result, the final carry SHALL be copied to cout, and the FSM SHALL move to DONE.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-022 Latency: with start sampled at edge e0, done SHALL be high in the cycle following edge eK (K+1 edges in total); throughput is one operation per K+2 cycles.
REQ-023 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-024 start SHALL be ignored while busy=1, with no effect on the in-flight operation; a start asserted in the IDLE cycle right after DONE SHALL be accepted.
REQ-025 result and cout SHALL change only on the transition to DONE and SHALL hold their values until the next completion or reset; partial sums are never visible on result.
REQ-026 Changes on a, b and sub after the start edge SHALL not affect the operation in flight.
REQ-027 With K=1, the FSM SHALL go IDLE -> RUN (one cycle) -> DONE.

Reset
REQ-028 When rst=1 at a rising edge, the FSM SHALL go to IDLE, cnt, the carry register and the accumulator SHALL be cleared, and busy=0, done=0, result=0, cout=0.
REQ-029 rst SHALL take priority over start, and an operation in progress SHALL be aborted with no done pulse.

Verification (N=16, K=4)
REQ-030 A bench SHALL check: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, start at e0 -> done high after e4, result=0x0000_0000_0000_0000, cout=1.
REQ-031 A bench SHALL check: a=5, b=7, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0; and a=7, b=5, sub=1 -> result=2, cout=1.
REQ-032 A bench SHALL check: a=0x0001_0000_FFFF_0000, b=0x0000_FFFF_0001_0000, sub=0 -> result=0x0002_0000_0000_0000, cout=0 (carry crosses chunk boundaries).
REQ-033 A bench SHALL check: start held high and a changed during RUN -> a single done pulse, the result reflects the operands latched at e0, and a new operation starts on the first IDLE cycle.
REQ-034 A bench SHALL check: rst=1 at edge e2 of an operation -> no done pulse, busy=0 and result=0 in the next cycle, and a new start completes normally.
REQ-035 A bench SHALL check, with K=1 and N=8: a=0x80, b=0x80, sub=0 -> done after e1, result=0x00, cout=1.
